// File: rtl/inst_pkg.sv
// Shared definitions for the 16-bit instruction format: opcodes, field positions,
// legality check and canonical encoder (also used by the Decoder bench).
package inst_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ALU   = 4'b0001;
    localparam logic [3:0] OP_MOVI  = 4'b0100;
    localparam logic [3:0] OP_MOVR  = 4'b0101;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_LOAD  = 4'b1010;
    localparam logic [3:0] OP_JUMP  = 4'b1100;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int A_MSB  = 11;
    localparam int A_LSB  = 6;
    localparam int B_MSB  = 5;
    localparam int B_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_NOP, OP_ALU, OP_MOVI, OP_MOVR, OP_STORE, OP_LOAD, OP_JUMP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // NOP is forced to all-zero so the Decoder sees a single canonical form.
    function automatic logic [15:0] encode(input logic [3:0] op, input logic [5:0] a,
                                           input logic [5:0] b);
        logic [15:0] w;
        w = '0;
        if (op != OP_NOP) begin
            w[OP_MSB:OP_LSB] = op;
            w[A_MSB:A_LSB]   = a;
            w[B_MSB:B_LSB]   = b;
        end
        return w;
    endfunction

endpackage

// File: rtl/inst_field_packer.sv
// Purpose: combinational legality check and canonical packing of one request.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is consumed.
module inst_field_packer
    import inst_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [5:0]  a,
    input  logic [5:0]  b,
    output logic        legal,
    output logic [15:0] word
);

    assign legal = is_legal_op(op);
    assign word  = encode(op, a, b);

endmodule

// File: rtl/inst_encoder_loader.sv
// Purpose: encodes symbolic requests and streams them into instruction memory; optional
// halt word via INST_ENC_AUTO_HALT_EN. Latency: accept-to-write exactly one cycle.
// Backpressure: req_ready high only in LOAD; one request per cycle, back-to-back.
module inst_encoder_loader
    import inst_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [5:0]        req_a,
    input  logic [5:0]        req_b,
    input  logic              req_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                wr_pend_q, wr_pend_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                err_ill_q, err_ill_d;
    logic                err_ovf_q, err_ovf_d;
    logic                pk_legal;
    logic [15:0]         pk_word;
    logic [ADDR_W:0]     used;

    inst_field_packer u_packer (
        .op    (req_op),
        .a     (req_a),
        .b     (req_b),
        .legal (pk_legal),
        .word  (pk_word)
    );

    // Words already committed, including the one being written this cycle.
    assign used = count_q + (ADDR_W+1)'(wr_pend_q);

`ifdef INST_ENC_AUTO_HALT_EN
    logic              halt_q, halt_d;
    logic [ADDR_W-1:0] halt_addr;
    logic [11:0]       halt_tgt;
    assign halt_addr = ptr_q + ADDR_W'(wr_pend_q);
    assign halt_tgt  = 12'(halt_addr);
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        wr_pend_d = 1'b0;
        wr_data_d = wr_data_q;
        err_ill_d = err_ill_q;
        err_ovf_d = err_ovf_q;
        req_ready = 1'b0;
`ifdef INST_ENC_AUTO_HALT_EN
        halt_d    = halt_q;
`endif
        if (wr_pend_q) begin
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W+1)'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d     = BASE;
                    count_d   = '0;
                    err_ill_d = 1'b0;
                    err_ovf_d = 1'b0;
`ifdef INST_ENC_AUTO_HALT_EN
                    halt_d    = 1'b0;
`endif
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!pk_legal) begin
                        err_ill_d = 1'b1;
                    end else if (used == CAP) begin
                        err_ovf_d = 1'b1;
                        state_d   = ST_FLUSH;
                    end else begin
                        wr_pend_d = 1'b1;
                        wr_data_d = pk_word;
                    end
                    if (req_last) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
`ifdef INST_ENC_AUTO_HALT_EN
                if (halt_q) begin
                    state_d = ST_DONE;
                end else if (used == CAP) begin
                    err_ovf_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    wr_pend_d = 1'b1;
                    wr_data_d = encode(OP_JUMP, halt_tgt[11:6], halt_tgt[5:0]);
                    halt_d    = 1'b1;
                end
`else
                state_d = ST_DONE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= BASE;
            count_q   <= '0;
            wr_pend_q <= 1'b0;
            wr_data_q <= '0;
            err_ill_q <= 1'b0;
            err_ovf_q <= 1'b0;
`ifdef INST_ENC_AUTO_HALT_EN
            halt_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            wr_pend_q <= wr_pend_d;
            wr_data_q <= wr_data_d;
            err_ill_q <= err_ill_d;
            err_ovf_q <= err_ovf_d;
`ifdef INST_ENC_AUTO_HALT_EN
            halt_q    <= halt_d;
`endif
        end
    end

    assign mem_we       = wr_pend_q;
    assign mem_addr     = ptr_q;
    assign mem_wdata    = wr_data_q;
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign done         = (state_q == ST_DONE);
    assign count        = count_q;
    assign err_illegal  = err_ill_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: a default-size instance and a 4-word instance
// share the request bus; each is started separately.
module tb_inst_encoder_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start0, start1, req_valid, req_last;
    logic [3:0]  req_op;
    logic [5:0]  req_a, req_b;

    logic        rdy0, we0, busy0, done0, ei0, eo0;
    logic [7:0]  addr0;
    logic [15:0] wdat0;
    logic [8:0]  cnt0;
    logic        rdy1, we1, busy1, done1, ei1, eo1;
    logic [1:0]  addr1;
    logic [15:0] wdat1;
    logic [2:0]  cnt1;

    inst_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .req_valid(req_valid), .req_ready(rdy0),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_last(req_last),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdat0), .busy(busy0), .done(done0),
        .count(cnt0), .err_illegal(ei0), .err_overflow(eo0)
    );

    inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .req_valid(req_valid), .req_ready(rdy1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_last(req_last),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdat1), .busy(busy1), .done(done1),
        .count(cnt1), .err_illegal(ei1), .err_overflow(eo1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_done  = 0;
    bit sel     = 1'b0;
    int lg_addr[$];
    int lg_data[$];
    int lg_cyc[$];

    logic [3:0] p_op[16];
    logic [5:0] p_a[16];
    logic [5:0] p_b[16];
    logic       p_last[16];
    int         p_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor for the instance currently under test, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!sel && we0) begin
                lg_addr.push_back(int'(addr0)); lg_data.push_back(int'(wdat0)); lg_cyc.push_back(cyc);
            end
            if (sel && we1) begin
                lg_addr.push_back(int'(addr1)); lg_data.push_back(int'(wdat1)); lg_cyc.push_back(cyc);
            end
            if (sel ? done1 : done0) n_done++;
        end
    end

    task automatic add_req(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                           input logic last);
        p_op[p_n] = op; p_a[p_n] = a; p_b[p_n] = b; p_last[p_n] = last;
        p_n++;
    endtask

    task automatic clear_log();
        lg_addr.delete(); lg_data.delete(); lg_cyc.delete();
        n_done = 0;
    endtask

    // Starts one instance and streams the program; acc = requests accepted.
    task automatic run_prog(input bit s, output int acc, output int first_acc);
        int  i;
        int  guard;
        logic r;
        sel = s;
        clear_log();
        first_acc = -1;
        @(negedge clk);
        if (s) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        i = 0; guard = 0;
        while (i < p_n && guard < 40) begin
            req_valid = 1'b1; req_op = p_op[i]; req_a = p_a[i]; req_b = p_b[i];
            req_last = p_last[i];
            r = s ? rdy1 : rdy0;
            if (r && i == 0) first_acc = cyc;
            @(negedge clk);
            guard++;
            if (r) i++;
            else if (!(s ? busy1 : busy0)) break;
        end
        acc = i;
        req_valid = 1'b0; req_last = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_state();
        n_tests++;
        if ({rdy0, we0, addr0, wdat0, busy0, done0, cnt0, ei0, eo0} !== '0) begin
            n_fail++;
            $display("FAIL reset_state_dut0: got rdy=%b we=%b addr=%h wdata=%h busy=%b done=%b cnt=%0d ei=%b eo=%b, want all 0",
                     rdy0, we0, addr0, wdat0, busy0, done0, cnt0, ei0, eo0);
        end
        n_tests++;
        if ({rdy1, we1, addr1, wdat1, busy1, done1, cnt1, ei1, eo1} !== '0) begin
            n_fail++;
            $display("FAIL reset_state_dut1: got we=%b addr=%h cnt=%0d busy=%b, want all 0",
                     we1, addr1, cnt1, busy1);
        end
    endtask

    task automatic test_basic();
        int acc, fa;
        int ea[$];
        int ed[$];
        p_n = 0;
        add_req(4'h1, 6'd1, 6'd2, 1'b0);
        add_req(4'h5, 6'd3, 6'd4, 1'b0);
        add_req(4'h9, 6'd5, 6'd6, 1'b1);
        ea = '{0, 1, 2};
        ed = '{16'h1042, 16'h50C4, 16'h9146};
`ifdef INST_ENC_AUTO_HALT_EN
        ea.push_back(3); ed.push_back(16'hC003);
`endif
        run_prog(1'b0, acc, fa);
        n_tests++;
        if (acc !== 3) begin n_fail++; $display("FAIL basic_accepts: got %0d want 3", acc); end
        n_tests++;
        if (lg_data.size() !== ed.size()) begin
            n_fail++; $display("FAIL basic_nwrites: got %0d want %0d", lg_data.size(), ed.size());
        end
        for (int i = 0; i < ed.size(); i++) begin
            n_tests++;
            if (i >= lg_data.size() || lg_addr[i] !== ea[i] || lg_data[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL basic_write%0d: got %0s want addr %0d data %h", i,
                         (i < lg_data.size()) ? $sformatf("addr %0d data %h", lg_addr[i], lg_data[i]) : "none",
                         ea[i], ed[i]);
            end
        end
        n_tests++;
        if (lg_cyc.size() < 3 || lg_cyc[0] !== fa + 1 || lg_cyc[1] !== fa + 2 || lg_cyc[2] !== fa + 3) begin
            n_fail++;
            $display("FAIL basic_timing: first accept cycle %0d, write cycles not at +1,+2,+3", fa);
        end
        n_tests++;
        if (cnt0 !== 9'(ed.size()) || n_done !== 1 || ei0 !== 1'b0 || eo0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_status: got count=%0d done_pulses=%0d ei=%b eo=%b want count=%0d done_pulses=1 ei=0 eo=0",
                     cnt0, n_done, ei0, eo0, ed.size());
        end
    endtask

    task automatic test_illegal();
        int acc, fa;
        int ea[$];
        int ed[$];
        p_n = 0;
        add_req(4'h1, 6'd1, 6'd2, 1'b0);
        add_req(4'h7, 6'd9, 6'd9, 1'b0);
        add_req(4'h5, 6'd3, 6'd4, 1'b1);
        ea = '{0, 1};
        ed = '{16'h1042, 16'h50C4};
`ifdef INST_ENC_AUTO_HALT_EN
        ea.push_back(2); ed.push_back(16'hC002);
`endif
        run_prog(1'b0, acc, fa);
        n_tests++;
        if (acc !== 3 || lg_data.size() !== ed.size()) begin
            n_fail++;
            $display("FAIL illegal_counts: got accepts=%0d writes=%0d want 3 and %0d", acc, lg_data.size(), ed.size());
        end
        for (int i = 0; i < ed.size(); i++) begin
            n_tests++;
            if (i >= lg_data.size() || lg_addr[i] !== ea[i] || lg_data[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL illegal_write%0d: want addr %0d data %h, got %0d writes", i, ea[i], ed[i], lg_data.size());
            end
        end
        n_tests++;
        if (ei0 !== 1'b1 || eo0 !== 1'b0 || cnt0 !== 9'(ed.size()) || n_done !== 1) begin
            n_fail++;
            $display("FAIL illegal_status: got ei=%b eo=%b count=%0d done_pulses=%0d want ei=1 eo=0 count=%0d done_pulses=1",
                     ei0, eo0, cnt0, n_done, ed.size());
        end
    endtask

    task automatic test_nop();
        int acc, fa;
        int ea[$];
        int ed[$];
        p_n = 0;
        add_req(4'h0, 6'h3F, 6'h3F, 1'b1);
        ea = '{0};
        ed = '{16'h0000};
`ifdef INST_ENC_AUTO_HALT_EN
        ea.push_back(1); ed.push_back(16'hC001);
`endif
        run_prog(1'b0, acc, fa);
        n_tests++;
        if (lg_data.size() !== ed.size()) begin
            n_fail++; $display("FAIL nop_nwrites: got %0d want %0d", lg_data.size(), ed.size());
        end
        for (int i = 0; i < ed.size(); i++) begin
            n_tests++;
            if (i >= lg_data.size() || lg_addr[i] !== ea[i] || lg_data[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL nop_write%0d: want addr %0d data %h, got %0s", i, ea[i], ed[i],
                         (i < lg_data.size()) ? $sformatf("addr %0d data %h", lg_addr[i], lg_data[i]) : "none");
            end
        end
        n_tests++;
        if (ei0 !== 1'b0 || cnt0 !== 9'(ed.size())) begin
            n_fail++;
            $display("FAIL nop_status: got ei=%b count=%0d want ei=0 count=%0d", ei0, cnt0, ed.size());
        end
    endtask

    task automatic test_overflow();
        int acc, fa;
        p_n = 0;
        for (int i = 0; i < 6; i++) add_req(4'h1, 6'd1, 6'(i), (i == 5) ? 1'b1 : 1'b0);
        run_prog(1'b1, acc, fa);
        n_tests++;
        if (acc !== 5 || lg_data.size() !== 4) begin
            n_fail++;
            $display("FAIL ovf_counts: got accepts=%0d writes=%0d want 5 and 4", acc, lg_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= lg_data.size() || lg_addr[i] !== i || lg_data[i] !== (16'h1040 + i)) begin
                n_fail++;
                $display("FAIL ovf_write%0d: want addr %0d data %h", i, i, 16'h1040 + i);
            end
        end
        n_tests++;
        if (eo1 !== 1'b1 || ei1 !== 1'b0 || cnt1 !== 3'd4 || n_done !== 1) begin
            n_fail++;
            $display("FAIL ovf_status: got eo=%b ei=%b count=%0d done_pulses=%0d want eo=1 ei=0 count=4 done_pulses=1",
                     eo1, ei1, cnt1, n_done);
        end
    endtask

    task automatic test_reset_mid_load();
        sel = 1'b0;
        clear_log();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        req_valid = 1'b1; req_op = 4'h1; req_a = 6'd1; req_b = 6'd2; req_last = 1'b0;
        @(negedge clk); req_b = 6'd3;
        @(negedge clk); req_valid = 1'b0;
        n_tests++;
        if (we0 !== 1'b1 || cnt0 !== 9'd1 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got we=%b count=%0d busy=%b want we=1 count=1 busy=1", we0, cnt0, busy0);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (we0 !== 1'b0 || cnt0 !== 9'd0 || busy0 !== 1'b0 || rdy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got we=%b count=%0d busy=%b rdy=%b want all 0", we0, cnt0, busy0, rdy0);
        end
        @(negedge clk); rst_n = 1'b1;
        clear_log();
        repeat (5) @(negedge clk);
        n_tests++;
        if (lg_data.size() !== 0 || busy0 !== 1'b0 || cnt0 !== 9'd0) begin
            n_fail++;
            $display("FAIL rst_after: got writes=%0d busy=%b count=%0d want 0 0 0", lg_data.size(), busy0, cnt0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; req_valid = 1'b0; req_last = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        repeat (2) @(negedge clk);
        test_reset_state();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset_state();
        test_basic();
        test_illegal();
        test_nop();
        test_overflow();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
